eb_buff_vc: RTL and testbench
=============================

# eb_buff_vc

Multi-channel elastic buffer: one shared valid/ready input port carries a channel tag, and each of NUM_CH channels has a private DEPTH-entry FIFO. A single output port drains the non-empty channels under round-robin arbitration. It is the virtual-channel successor of the single-channel generic EB/FIFO wrapper. It sits between pipeline stages that multiplex independent streams, such as per-lane vector requests, where head-of-line blocking between streams is not acceptable.

## Interface
- DW, 32, payload width in bits
- NUM_CH, 2, number of channels (≥2)
- DEPTH, 4, entries per channel (power of two, ≥2)
- CW = $clog2(NUM_CH), CNTW = $clog2(DEPTH)+1 (localparams)
- clk  input  1  clock; single clock domain
- rst  input  1  synchronous, active-high reset
- data_i  input  DW  input payload
- ch_i  input  CW  target channel of data_i
- valid_i  input  1  input valid
- ready_o  output  1  the channel selected by ch_i can accept this cycle
- flush_i  input  NUM_CH  per-channel flush request
- data_o  output  DW  head payload of the granted channel; 0 when valid_o=0
- ch_o  output  CW  granted channel; 0 when valid_o=0
- valid_o  output  1  output valid
- ready_i  input  1  downstream ready
- count_o  output  NUM_CH*CNTW  per-channel occupancy; channel k is at [k*CNTW +: CNTW]

## Operation
- Per channel: storage of DEPTH×DW, read and write pointers of $clog2(DEPTH) bits that wrap naturally, and a count register of CNTW bits. full = (count==DEPTH), empty = (count==0).
- ready_o = !full[ch_i] & !flush_i[ch_i] (flush term only when the flush feature is compiled in). ready_o does not depend on ready_i, so there is no combinational path from the output back to the input.
- Push: valid_i & ready_o. Data is written at the write pointer of channel ch_i, the pointer increments and the count increments.
- Arbitration:
  - rr_ptr (CW bits) names the highest-priority channel.
  - The grant is the first non-empty channel found scanning cyclically from rr_ptr.
  - The grant is also qualified by !flush_i[ch] for that channel.
- Lock: if valid_o & !ready_i, register lock=1 and lock_ch=grant. While lock=1, grant=lock_ch. data_o and ch_o stay stable until the transfer completes; the only exception is flush.
- Pop: valid_o & ready_i. The granted channel's read pointer increments and its count decrements. lock clears and rr_ptr becomes grant+1 modulo NUM_CH; wrap from NUM_CH-1 goes to 0, including when NUM_CH is not a power of two.
- Simultaneous push and pop on the same channel: both take effect and count is unchanged. A full channel cannot push even if it is popped in the same cycle.
- Flush of channel k (feature on):
  - Next cycle, channel k's pointers and count are 0.
  - A push to k in the same cycle is blocked, because ready_o=0.
  - If k is granted or locked, valid_o is forced 0 that cycle, the lock is cleared and rr_ptr is unchanged.
- Entries never cross channels. Order within a channel is strict FIFO.

## Timing
- Reset (rst=1 at a clk edge) sets all counts, pointers, rr_ptr, lock and lock_ch to 0. After reset: valid_o=0, data_o=0, ch_o=0, ready_o=1, count_o=0.
- Reset asserted mid-operation discards all contents in that cycle, regardless of the other inputs.
- Storage is not reset.
- Latency: data pushed at edge t is visible on data_o from cycle t+1, provided its channel wins the grant. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- valid_o, data_o and ch_o are a combinational function of registered state plus flush_i. They do not depend on valid_i or ready_i.
- count_o is registered.

## Configuration
- EB_BUFF_VC_FLUSH_EN defined: flush_i behaves as described above.
- Undefined: flush_i is present but ignored, the flush terms are removed from ready_o and the grant logic, and no flush logic is synthesized.

## Test plan
- Reset, then push A0,A1 to ch0 and B0 to ch1 back-to-back with ready_i=1 → output order A0 (ch0), B0 (ch1), A1 (ch0); count_o returns to 0.
- Fill ch0 with 4 entries (DEPTH=4) while ready_i=0 → ready_o=0 for ch_i=0 and 1 for ch_i=1. Push to ch1 succeeds. count_o = {1,4}.
- ready_i=0 with ch1 granted and holding B0; then push to ch0 → data_o=B0 and ch_o=1 held stable until ready_i=1.
- Full ch0 with push and pop in the same cycle → push rejected, count 4→3. Non-full ch0 with push and pop in the same cycle → count unchanged.
- Flush feature on: ch1 holds 3 entries and is locked; assert flush_i=2'b10 while pushing to ch1 → valid_o=0 that cycle, ready_o=0, ch1 count becomes 0 next cycle, and ch0 traffic is unaffected.
- Reset asserted with both channels non-empty and a transfer pending → next cycle valid_o=0, count_o=0, ready_o=1.

Source files
------------

// File: rtl/eb_buff_vc.sv
// rtl/eb_buff_vc.sv - multi-channel elastic buffer with round-robin drain; optional flush via EB_BUFF_VC_FLUSH_EN
module eb_buff_vc #(
  parameter int DW     = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DW-1:0]                    data_i,
  input  logic [$clog2(NUM_CH)-1:0]        ch_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [NUM_CH-1:0]                flush_i,
  output logic [DW-1:0]                    data_o,
  output logic [$clog2(NUM_CH)-1:0]        ch_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] count_o
);

  localparam int CW   = $clog2(NUM_CH);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int PW   = $clog2(DEPTH);

  logic [DW-1:0]   mem    [NUM_CH][DEPTH];
  logic [PW-1:0]   wr_ptr [NUM_CH];
  logic [PW-1:0]   rd_ptr [NUM_CH];
  logic [CNTW-1:0] cnt    [NUM_CH];
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   lock_ch;
  logic            lock;

  logic [NUM_CH-1:0] flush;
  logic [NUM_CH-1:0] ne;
  logic [CW-1:0]     scan_grant;
  logic              scan_found;
  logic [CW-1:0]     grant;
  logic              push;
  logic              pop;

`ifdef EB_BUFF_VC_FLUSH_EN
  assign flush = flush_i;
`else
  // Flush is compiled out; the port stays for drop-in compatibility.
  logic unused_flush;
  assign unused_flush = ^flush_i;
  assign flush = '0;
`endif

  // A channel is eligible for grant when it holds data and is not being flushed.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ne[k] = (cnt[k] != '0) && !flush[k];
    end
  end

  // Cyclic scan from rr_ptr for the first eligible channel.
  always_comb begin : rr_scan
    int idx;
    scan_grant = '0;
    scan_found = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!scan_found && ne[idx]) begin
        scan_found = 1'b1;
        scan_grant = CW'(idx);
      end
    end
  end

  // Output mux: a stalled transfer keeps its channel until it completes or is flushed.
  always_comb begin
    grant   = lock ? lock_ch : scan_grant;
    valid_o = lock ? ne[lock_ch] : scan_found;
    data_o  = valid_o ? mem[grant][rd_ptr[grant]] : '0;
    ch_o    = valid_o ? grant : '0;
    ready_o = (cnt[ch_i] != CNTW'(DEPTH)) && !flush[ch_i];
    push    = valid_i && ready_o;
    pop     = valid_o && ready_i;
  end

  // Per-channel occupancy, packed channel 0 at the LSBs.
  always_comb begin
    count_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      count_o[k*CNTW +: CNTW] = cnt[k];
    end
  end

  // Payload storage; never reset.
  always_ff @(posedge clk) begin
    if (push) mem[ch_i][wr_ptr[ch_i]] <= data_i;
  end

  // Pointers, counts, lock and round-robin state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_ch <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (flush[k]) begin
          wr_ptr[k] <= '0;
          rd_ptr[k] <= '0;
          cnt[k]    <= '0;
        end else begin
          if (push && ch_i == CW'(k)) wr_ptr[k] <= wr_ptr[k] + 1'b1;
          if (pop && grant == CW'(k)) rd_ptr[k] <= rd_ptr[k] + 1'b1;
          cnt[k] <= cnt[k] + CNTW'(push && ch_i == CW'(k)) - CNTW'(pop && grant == CW'(k));
        end
      end
      lock <= valid_o && !ready_i;
      if (valid_o && !ready_i) lock_ch <= grant;
      if (pop) rr_ptr <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + CW'(1);
    end
  end

endmodule

// File: tb/tb_eb_buff_vc.sv
// tb/tb_eb_buff_vc.sv - directed self-checking bench for eb_buff_vc
module tb_eb_buff_vc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i;
  logic        ch_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  flush_i;
  logic [31:0] data_o;
  logic        ch_o;
  logic        valid_o;
  logic        ready_i;
  logic [5:0]  count_o;

  int total = 0;
  int bad   = 0;

  eb_buff_vc #(.DW(32), .NUM_CH(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .ch_i(ch_i), .valid_i(valid_i),
    .ready_o(ready_o), .flush_i(flush_i), .data_o(data_o), .ch_o(ch_o),
    .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs just after an edge and let combinational outputs settle.
  task automatic drive(input logic v, input logic c, input logic [31:0] d, input logic r, input logic [1:0] f);
    valid_i = v; ch_i = c; data_i = d; ready_i = r; flush_i = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // count_o packing: ch1 at [5:3], ch0 at [2:0]
  function automatic logic [63:0] cnt2(input int c1, input int c0);
    return 64'((c1 << 3) | c0);
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data",  data_o,  0);
    check("rst_ch",    ch_o,    0);
    check("rst_ready", ready_o, 1);
    check("rst_count", count_o, 0);

    // Interleaved traffic: pushes A0(ch0), B0(ch1), A1(ch0), ready_i=1.
    drive(1'b1, 1'b0, 32'hA000_0000, 1'b1, 2'b00);
    check("t1_empty", valid_o, 0);
    tick();
    drive(1'b1, 1'b1, 32'hB000_0000, 1'b1, 2'b00);
    check("t1_o0_d", data_o, 32'hA000_0000);
    check("t1_o0_c", ch_o, 0);
    tick();
    drive(1'b1, 1'b0, 32'hA000_0001, 1'b1, 2'b00);
    check("t1_o1_d", data_o, 32'hB000_0000);
    check("t1_o1_c", ch_o, 1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 2'b00);
    check("t1_o2_d", data_o, 32'hA000_0001);
    check("t1_o2_c", ch_o, 0);
    tick();
    check("t1_drained", valid_o, 0);
    check("t1_count", count_o, 0);

    // Fill ch0 with ready_i=0.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'hD000_0000 + i, 1'b0, 2'b00);
      check("t2_fill_rdy", ready_o, 1);
      tick();
    end
    drive(1'b1, 1'b0, 32'hDEAD_0000, 1'b0, 2'b00);
    check("t2_full_rdy0", ready_o, 0);
    tick();
    check("t2_full_cnt", count_o, cnt2(0, 4));
    drive(1'b1, 1'b1, 32'hE000_0000, 1'b0, 2'b00);
    check("t2_rdy1", ready_o, 1);
    tick();
    check("t2_count", count_o, cnt2(1, 4));
    check("t2_head", data_o, 32'hD000_0000);
    check("t2_head_ch", ch_o, 0);

    // Full ch0: push and pop same cycle, push rejected.
    drive(1'b1, 1'b0, 32'hBAD0_0000, 1'b1, 2'b00);
    check("t4_full_rdy", ready_o, 0);
    check("t4_pop_d", data_o, 32'hD000_0000);
    tick();
    check("t4_full_cnt", count_o, cnt2(1, 3));
    // Non-full ch1 then ch0: push and pop same channel, count unchanged.
    drive(1'b1, 1'b1, 32'hF000_0000, 1'b1, 2'b00);
    check("t4_rr_d", data_o, 32'hE000_0000);
    check("t4_rr_c", ch_o, 1);
    tick();
    check("t4_ch1_cnt", count_o, cnt2(1, 3));
    drive(1'b1, 1'b0, 32'hC000_0000, 1'b1, 2'b00);
    check("t4_ch0_d", data_o, 32'hD000_0001);
    tick();
    check("t4_ch0_cnt", count_o, cnt2(1, 3));

    // Stall on ch1 holding F0 while ch0 receives a push.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    check("t3_d0", data_o, 32'hF000_0000);
    check("t3_c0", ch_o, 1);
    tick();
    drive(1'b1, 1'b0, 32'h1100_0000, 1'b0, 2'b00);
    check("t3_d1", data_o, 32'hF000_0000);
    check("t3_c1", ch_o, 1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    check("t3_d2", data_o, 32'hF000_0000);
    check("t3_c2", ch_o, 1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 2'b00);
    check("t3_d3", data_o, 32'hF000_0000);
    tick();
    check("t3_cnt", count_o, cnt2(0, 4));

    // Drain ch0 in FIFO order.
    begin
      logic [31:0] exp_q [4];
      exp_q[0] = 32'hD000_0002; exp_q[1] = 32'hD000_0003;
      exp_q[2] = 32'hC000_0000; exp_q[3] = 32'h1100_0000;
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 1'b0, 32'h0, 1'b1, 2'b00);
        check("drain_d", data_o, exp_q[i]);
        check("drain_c", ch_o, 0);
        tick();
      end
    end
    check("drain_empty", valid_o, 0);

    // ch1 gets 3 entries and locks; ch0 gets one.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h2200_0000 + i, 1'b0, 2'b00);
      tick();
    end
    drive(1'b1, 1'b0, 32'h3300_0000, 1'b0, 2'b00);
    tick();
    check("fl_pre_cnt", count_o, cnt2(3, 1));
    drive(1'b1, 1'b1, 32'h4400_0000, 1'b0, 2'b10);
`ifdef EB_BUFF_VC_FLUSH_EN
    check("fl_valid", valid_o, 0);
    check("fl_ready", ready_o, 0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    check("fl_cnt", count_o, cnt2(0, 1));
    check("fl_ch0_d", data_o, 32'h3300_0000);
    check("fl_ch0_c", ch_o, 0);
`else
    check("nofl_valid", valid_o, 1);
    check("nofl_data", data_o, 32'h2200_0000);
    check("nofl_ready", ready_o, 1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    check("nofl_cnt", count_o, cnt2(4, 1));
    check("nofl_ch", ch_o, 1);
`endif

    // Make both channels non-empty with a transfer pending, then reset.
    drive(1'b1, 1'b1, 32'h5500_0000, 1'b0, 2'b00);
    tick();
    check("prerst_valid", valid_o, 1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h6600_0000, 1'b1, 2'b00);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 2'b00);
    check("mrst_valid", valid_o, 0);
    check("mrst_count", count_o, 0);
    check("mrst_ready", ready_o, 1);
    check("mrst_data",  data_o,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
